// File: rtl/reg_dump_seq_pkg.sv
// Shared types and defaults for the run-then-dump register sequencer.
package reg_dump_seq_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int CNT_W_DEF    = 12;
    localparam int IDX_W        = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FETCH,
        S_PRESENT,
        S_DONE
    } state_t;

endpackage

// File: rtl/reg_dump_seq.sv
// Runs the processor for a programmed number of cycles, then streams out the register file.
// Define REG_DUMP_SKIP_ZERO_EN to skip register 0 in the dump.
module reg_dump_seq
    import reg_dump_seq_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_cycles,
    output logic             cpu_run,
    input  logic [4:0]       cpu_rs1,
    output logic [4:0]       rf_rs1,
    input  logic [31:0]      rf_dataA,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [4:0]       dump_idx,
    output logic [31:0]      dump_data,
    output logic [CNT_W-1:0] cycle_count,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
`ifdef REG_DUMP_SKIP_ZERO_EN
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
`else
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(0);
`endif

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt_lim;
    logic             run_last;

    // Last run cycle is the one whose pre-increment count equals limit-1.
    assign run_last = (cycle_count == cnt_lim - CNT_W'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cpu_run    = 1'b0;
        dump_valid = 1'b0;
        done       = 1'b0;
        rf_rs1     = idx;
        case (state)
            S_IDLE, S_DONE: begin
                rf_rs1 = (state == S_IDLE) ? cpu_rs1 : idx;
                done   = (state == S_DONE);
                if (start) state_nxt = (num_cycles == '0) ? S_FETCH : S_RUN;
            end
            S_RUN: begin
                cpu_run = 1'b1;
                rf_rs1  = cpu_rs1;
                if (run_last) state_nxt = S_FETCH;
            end
            S_FETCH:   state_nxt = S_PRESENT;
            S_PRESENT: begin
                dump_valid = 1'b1;
                if (dump_ready) state_nxt = (idx == LAST_IDX) ? S_DONE : S_FETCH;
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx         <= '0;
            cnt_lim     <= '0;
            cycle_count <= '0;
            dump_idx    <= '0;
            dump_data   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cnt_lim     <= num_cycles;
                        cycle_count <= '0;
                        idx         <= FIRST_IDX;
                    end
                end
                S_RUN: cycle_count <= cycle_count + CNT_W'(1);
                S_FETCH: begin
                    dump_data <= rf_dataA;
                    dump_idx  <= idx;
                end
                S_PRESENT: begin
                    // Index saturates at the last register; DONE takes over from there.
                    if (dump_ready && idx != LAST_IDX) idx <= idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/reg_dump_seq.md
REG_DUMP_SEQ -- requirements
Module: reg_dump_seq

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32: number of architectural registers dumped.
REQ-002 SHALL have parameter CNT_W, default 12: width of the run-cycle counter.
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a run-then-dump sequence.
REQ-006 SHALL have port num_cycles  input  CNT_W  number of clock cycles the processor runs; sampled only on an accepted start.
REQ-007 SHALL have port cpu_run  output  1  processor advance enable; low stalls the processor.
REQ-008 SHALL have port cpu_rs1  input  5  processor's register-file read-port-A index.
REQ-009 SHALL have port rf_rs1  output  5  index driven to register-file read port A.
REQ-010 SHALL have port rf_dataA  input  32  register-file read-port-A data, combinational from rf_rs1.
REQ-011 SHALL have ports dump_valid  output  1; dump_ready  input  1: beat handshake.
REQ-012 SHALL have ports dump_idx  output  5; dump_data  output  32: register index and value of the current beat.
REQ-013 SHALL have port cycle_count  output  CNT_W  run cycles elapsed in the current sequence.
REQ-014 SHALL have port done  output  1  high in DONE state.

Function
REQ-015 SHALL implement states IDLE, RUN, FETCH, PRESENT, DONE.
REQ-016 IDLE/DONE: start=1 SHALL latch num_cycles, clear cycle_count, load the index with the first dump index, and go to RUN, or to FETCH if num_cycles==0.
REQ-017 RUN: cpu_run=1, cycle_count increments each cycle, and the state SHALL go to FETCH on the cycle cycle_count reaches the latched value minus 1, so exactly num_cycles cycles have cpu_run=1.
REQ-018 rf_rs1 SHALL equal cpu_rs1 in IDLE and RUN, and SHALL equal the dump index in FETCH, PRESENT and DONE.
REQ-019 FETCH: lasts one cycle, SHALL capture rf_dataA into dump_data and the index into dump_idx, then go to PRESENT.
REQ-020 PRESENT: dump_valid=1, and dump_data/dump_idx SHALL hold stable until the beat is accepted (dump_valid & dump_ready).
REQ-021 On acceptance with index < NUM_REGS-1, the block SHALL increment the index and go to FETCH; with index == NUM_REGS-1, it SHALL go to DONE.
REQ-022 dump_ready high outside PRESENT SHALL have no effect; dump_valid SHALL never drop before acceptance.
REQ-023 start outside IDLE/DONE SHALL be ignored; the sequence SHALL not be restartable mid-operation.
REQ-024 cpu_run SHALL be 0 in every state except RUN; cycle_count SHALL hold its final value through FETCH/PRESENT/DONE.
REQ-025 Index arithmetic SHALL be 5-bit unsigned and SHALL never wrap past NUM_REGS-1.

Reset
REQ-026 reset SHALL asynchronously force state IDLE; cpu_run, dump_valid, done=0; dump_idx, dump_data, cycle_count, index, latched count=0.
REQ-027 reset asserted in any state, including mid-beat in PRESENT, SHALL abort the sequence with no further beats.

Configuration
REQ-028 Macro REG_DUMP_SKIP_ZERO_EN, when defined, SHALL make the first dump index 1, giving NUM_REGS-1 beats.
REQ-029 Without REG_DUMP_SKIP_ZERO_EN, the first dump index SHALL be 0, giving NUM_REGS beats.

Structure
REQ-030 A shared package SHALL hold the state enum typedef, the NUM_REGS/CNT_W defaults, and the register-index width constant (5).
REQ-031 The block SHALL be a single module with no sub-module; counter and FSM are inline.

Verification
REQ-032 num_cycles=10, start pulse, dump_ready tied 1 -> cpu_run high exactly 10 cycles, cycle_count=10, then 32 beats idx 0..31 one every 2 cycles, then done=1.
REQ-033 num_cycles=0 -> cpu_run never high, cycle_count=0, dump begins the cycle after start.
REQ-034 Pre-load r5=0xDEADBEEF, hold dump_ready=0 for 7 cycles during the idx=5 beat -> dump_valid stays 1, dump_data stays 0xDEADBEEF, and idx advances only after ready.
REQ-035 start pulses in RUN and PRESENT -> ignored; beat count unchanged; start in DONE -> new sequence runs.
REQ-036 reset asserted in PRESENT at idx=12 -> immediately IDLE, dump_valid=0, outputs zeroed, no further beats.
REQ-037 Build with REG_DUMP_SKIP_ZERO_EN -> 31 beats, first dump_idx=1, last=31, then done=1.
